// File: rtl/aes_pkg.sv
// Shared AES types, the reduction polynomial and GF(2^8) helper functions
// used by the round-stage datapath.
package aes_pkg;

    localparam int AES_DATA_W = 128;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] AES_POLY = 8'h1b;

    // Multiply by 2 in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by 3 in GF(2^8): 3x = 2x ^ x.
    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_addkey_stage_mix_column.sv
// MixColumns on a single 32-bit column. Row 0 sits in the top byte, so
// a0 = col[31:24] and a3 = col[7:0]. Purely combinational.
import aes_pkg::*;

module mix_column (
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // Circulant matrix {2,3,1,1} applied to the column.
    assign r0 = xtime(a0) ^ gmul3(a1) ^ a2        ^ a3;
    assign r1 = a0        ^ xtime(a1) ^ gmul3(a2) ^ a3;
    assign r2 = a0        ^ a1        ^ xtime(a2) ^ gmul3(a3);
    assign r3 = gmul3(a0) ^ a1        ^ a2        ^ xtime(a3);

    assign mixed = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_addkey_stage.sv
// AES MixColumns + AddRoundKey stage with a two-entry (main + skid) output
// buffer. in_ready comes straight from a flop so the downstream stall path
// never reaches the upstream stage.
// Optional build macro MIXKEY_STATS_EN adds saturating transfer/stall counters.
import aes_pkg::*;

module mix_addkey_stage #(
    parameter int DATA_W  = 128,
    parameter int STATS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [DATA_W-1:0]  in_key,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last
`ifdef MIXKEY_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_xfer,
    output logic [STATS_W-1:0] stat_stall
`endif
);

    // Elaboration-time guards on the parameters.
    if (DATA_W != AES_DATA_W) begin : g_bad_data_w
        $error("mix_addkey_stage: DATA_W must be 128");
    end
    if (STATS_W < 1) begin : g_bad_stats_w
        $error("mix_addkey_stage: STATS_W must be at least 1");
    end

    aes_state_t mixed;
    aes_state_t result;

    // One MixColumns unit per column; column c occupies bits [127-32c -: 32].
    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_column u_mix_column (
            .col   (in_data[127-32*c -: 32]),
            .mixed (mixed[127-32*c -: 32])
        );
    end

    // The final round skips MixColumns; the key is always added.
    assign result = (in_last ? in_data : mixed) ^ in_key;

    logic       main_valid;
    aes_state_t main_data;
    logic       main_last;
    logic       skid_full;
    aes_state_t skid_data;
    logic       skid_last;
    logic       in_ready_q;
    logic       accept;
    logic       main_free;

    assign accept    = in_valid & in_ready_q;
    // Main can take new content when it is empty or is being drained now.
    assign main_free = ~main_valid | out_ready;

    // Main/skid buffer: main refills from skid first, otherwise from the
    // input; skid only catches an accepted state while main is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the data registers are reset too, so out_data is a known
            // value from the first cycle after reset rather than X.
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            skid_full  <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (main_free) begin
            if (skid_full) begin
                // in_ready is low while skid is full, so no accept can
                // coincide with this refill.
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_last  <= skid_last;
                skid_full  <= 1'b0;
                in_ready_q <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments keep every flop in this block
                // sampling pre-edge values, independent of statement order.
                main_valid <= accept;
                if (accept) begin
                    main_data <= result;
                    main_last <= in_last;
                end
            end
        end else if (accept) begin
            skid_data  <= result;
            skid_last  <= in_last;
            skid_full  <= 1'b1;
            in_ready_q <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_last  = main_last;

`ifdef MIXKEY_STATS_EN
    // Saturating counters of output transfers and output stall cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_xfer  <= '0;
            stat_stall <= '0;
        end else begin
            if (main_valid && out_ready && (stat_xfer != '1)) begin
                stat_xfer <= stat_xfer + STATS_W'(1);
            end
            if (main_valid && !out_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mix_addkey_stage.sv
// Self-checking bench for mix_addkey_stage: a GF(2^8) matrix model plus a
// depth-2 FIFO scoreboard checked every cycle, directed FIPS-197 vectors,
// backpressure, throughput, reset-under-stall and a randomized phase.
// Build with +define+MIXKEY_STATS_EN to also check the statistics counters.
module tb_mix_addkey_stage;

    localparam int STATS_W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
`ifdef MIXKEY_STATS_EN
    logic [STATS_W-1:0] stat_xfer;
    logic [STATS_W-1:0] stat_stall;
`endif

    always #5 clk = ~clk;

    mix_addkey_stage #(.DATA_W(128), .STATS_W(STATS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef MIXKEY_STATS_EN
        ,
        .stat_xfer (stat_xfer),
        .stat_stall(stat_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic last);
        logic [7:0]   coef [4];
        logic [127:0] m;
        logic [7:0]   acc;
        coef = '{8'd2, 8'd3, 8'd1, 8'd1};
        m = d;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++)
                        acc ^= gf_mul(coef[(j - r + 4) % 4], d[127-8*(4*c+j) -: 8]);
                    m[127-8*(4*c+r) -: 8] = acc;
                end
            end
        end
        return m ^ k;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t         q[$];
    logic [127:0] pop_log[$];
    bit           live = 0;
    int           n_acc = 0;
    int           n_pop = 0;
    logic [STATS_W-1:0] m_xfer = '0;
    logic [STATS_W-1:0] m_stall = '0;

    // Model update on each rising edge using pre-edge values.
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            live    = 1;
            m_xfer  = '0;
            m_stall = '0;
        end else if (live) begin
            exp_t e;
            bit   can_take;
            can_take = (q.size() < 2);
            if (q.size() > 0) begin
                if (out_ready) begin
                    if (m_xfer != '1) m_xfer = m_xfer + 1;
                    pop_log.push_back(out_data);
                    void'(q.pop_front());
                    n_pop++;
                end else begin
                    if (m_stall != '1) m_stall = m_stall + 1;
                end
            end
            if (in_valid && can_take) begin
                e.data = model(in_data, in_key, in_last);
                e.last = in_last;
                q.push_back(e);
                n_acc++;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (live && rst) begin
            check("out_valid", out_valid, q.size() > 0);
            check("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0) begin
                check("out_data", out_data, q[0].data);
                check("out_last", out_last, q[0].last);
            end
`ifdef MIXKEY_STATS_EN
            check("stat_xfer", stat_xfer, m_xfer);
            check("stat_stall", stat_stall, m_stall);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l,
                        output int cycles);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_last  = l;
        cycles   = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!ok && cycles < 50);
        check("send_accepted", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [127:0] FIPS_D   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_K   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] COL_D    = {32'hdb135345, 96'h0};
    localparam logic [127:0] COL_OUT  = {32'h8e4da1bc, 96'h0};
    localparam logic [127:0] BYP_D    = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int           cyc;
        int           total;
        int           p0;
        int           a0;
        logic [127:0] bp   [4];
        logic [127:0] bpk;
        logic [127:0] td;
        logic [127:0] tk;
        bit           hs;

        // Pin the model itself against known answers.
        check("model_fips", model(FIPS_D, FIPS_K, 1'b0), FIPS_OUT);
        check("model_col", model(COL_D, '0, 1'b0), COL_OUT);
        check("model_bypass", model(BYP_D, '0, 1'b1), BYP_D);

        // Reset.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", out_last, 1'b0);
        rst = 1'b1;
        idle(1);

        // FIPS-197 round 1, latency 1.
        out_ready = 1'b1;
        send(FIPS_D, FIPS_K, 1'b0, cyc);
        check("fips_valid", out_valid, 1'b1);
        check("fips_data", out_data, FIPS_OUT);
        check("fips_last", out_last, 1'b0);
        idle(1);

        // Single column.
        send(COL_D, '0, 1'b0, cyc);
        check("col_data", out_data, COL_OUT);
        idle(1);

        // Final-round bypass.
        send(BYP_D, '0, 1'b1, cyc);
        check("bypass_data", out_data, BYP_D);
        check("bypass_last", out_last, 1'b1);
        idle(2);

        // Backpressure: 4 states, out_ready low for 3 cycles.
        bpk = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 4; i++) bp[i] = {$urandom(), $urandom(), $urandom(), 32'(i)};
        pop_log.delete();
        a0 = n_acc;
        p0 = n_pop;
        out_ready = 1'b0;
        fork
            begin
                int c;
                for (int i = 0; i < 4; i++) send(bp[i], bpk, 1'b0, c);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("bp_two_accepts", n_acc - a0, 2);
                check("bp_in_ready_low", in_ready, 1'b0);
                out_ready = 1'b1;
            end
        join
        total = 0;
        while (n_pop - p0 < 4 && total < 20) begin
            idle(1);
            total++;
        end
        idle(2);
        check("bp_pop_count", n_pop - p0, 4);
        check("bp_log_size", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("bp_order", pop_log[i], model(bp[i], bpk, 1'b0));

        // Full throughput: 16 back-to-back states.
        p0 = n_pop;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            td = {$urandom(), $urandom(), $urandom(), $urandom()};
            tk = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(td, tk, 1'(i % 5 == 4), cyc);
            total += cyc;
            check("tp_valid", out_valid, 1'b1);
            check("tp_data", out_data, model(td, tk, 1'(i % 5 == 4)));
        end
        check("tp_cycles", total, 16);
        idle(1);
        check("tp_pops", n_pop - p0, 16);
        idle(1);

        // Reset while the skid is full.
        out_ready = 1'b0;
        send({$urandom(), $urandom(), $urandom(), $urandom()}, '0, 1'b0, cyc);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, '0, 1'b0, cyc);
        check("stall_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_data", out_data, '0);
`ifdef MIXKEY_STATS_EN
        check("midrst_stat_xfer", stat_xfer, '0);
        check("midrst_stat_stall", stat_stall, '0);
`endif
        out_ready = 1'b1;
        idle(2);
        check("midrst_no_output", out_valid, 1'b0);

        // Randomized traffic; in_valid is held until accepted.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || hs) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_last  = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        // Wait until an in-flight offer is taken, then drain.
        total = 0;
        while (in_valid && total < 20) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) in_valid = 1'b0;
            total++;
        end
        check("rand_offer_taken", in_valid, 1'b0);
        out_ready = 1'b1;
        idle(4);
        check("drain_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);
        check("acc_eq_pop_plus_dropped", n_acc >= n_pop, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mix_addkey_stage.md
Name: mix_addkey_stage

Overview:
- AES round stage directly downstream of the combined ShiftRows/SubBytes stage.
- Takes a 128-bit state and applies MixColumns, skipped on the final round. It then XORs the round key (AddRoundKey) and registers the result.
- Valid/ready handshake on both sides, with an internal skid buffer so `in_ready` is driven purely from a register and the stall path is cut.
- Sustains 1 state/cycle; output feeds the next round's ShiftSub or the GCM keystream XOR.

Parameters:
- DATA_W, 128, state width; fixed at 128, kept for package consistency and checked by an elaboration assertion.
- STATS_W, 32, width of the optional statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- in_valid  input  1  upstream state/key valid
- in_ready  output  1  stage can accept; registered
- in_data  input  128  state after ShiftRows/SubBytes; byte s(r,c) = bits [127-8*(4c+r) -: 8]
- in_key  input  128  round key, same byte layout
- in_last  input  1  final round: bypass MixColumns
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  128  state after AddRoundKey
- out_last  output  1  in_last carried alongside out_data

Behaviour:
- Reset (rst=0 at posedge): out_valid=0, out_data=0, out_last=0, skid empty, in_ready=1. Reset mid-transfer drops all held states; no partial output.
- Datapath per column c, bytes a0..a3:
  - r0=2a0^3a1^a2^a3; r1=a0^2a1^3a2^a3; r2=a0^a1^2a2^3a3; r3=3a0^a1^a2^2a3.
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0); 3x = 2x ^ x.
  - result = (in_last ? in_data : MixColumns(in_data)) ^ in_key. Computed combinationally on the input side, before any register.
- Accept: a transfer occurs when in_valid & in_ready at a posedge.
- Output register (main): loads when empty or when out_ready=1 (being drained).
- Skid register: captures the accepted result when main is full and out_ready=0.
- in_ready is the registered !skid_full.
- Output latency: 1 cycle from accept to out_valid when there is no stall.
- Stalls:
  - out_valid & !out_ready holds out_data/out_last stable.
  - The skid holds at most one extra state; then in_ready drops on the next cycle.
- Skid draining: on out_ready with skid full, main takes the skid content and the skid empties. in_ready rises the following cycle.
- Simultaneous accept + drain with skid empty: main is reloaded with the new result, with no bubble.
- Ordering: strict FIFO, depth 2; no reordering or duplication.
- out_data is never X after reset.
- Protocol rule: in_valid must not be retracted while in_ready=0.

Optional Feature:
- Macro MIXKEY_STATS_EN.
- Defined: adds outputs stat_xfer [STATS_W-1:0] and stat_stall [STATS_W-1:0].
  - stat_xfer counts output transfers (out_valid & out_ready).
  - stat_stall counts cycles with out_valid & !out_ready.
  - Both saturate at all-ones, clear on reset, and count in the same cycle as the event.
- Undefined: those ports and counters are absent; the datapath is otherwise identical.

Decomposition:
- aes_pkg holds:
  - typedef aes_state_t (logic [127:0]) and aes_word_t (logic [31:0]);
  - constant AES_POLY = 8'h1b;
  - functions xtime() and gmul3().
- Sub-module mix_column: combinational, 32-bit column in/out, instantiated 4x.
- The skid-buffer logic stays inline.

Test Plan:
- FIPS-197 App. B round 1, single transfer:
  - in_data=d4bf5d30e0b452aeb84111f11e2798e5, in_key=a0fafe1788542cb123a339392a6c7605, in_last=0.
  - Expect out_data=a49c7ff2689f352b6b5bea43026a5049 one cycle later.
- Column check: column 0 = db135345, key 0, in_last=0 -> out column 0 = 8e4da1bc.
- Last-round bypass: in_last=1, in_key=0, in_data=00112233445566778899aabbccddeeff -> out_data equal to in_data, out_last=1.
- Backpressure:
  - Stream 4 distinct states with out_ready=0 for 3 cycles: in_ready falls after 2 accepts.
  - Release out_ready: all 4 states emerge in order, with none lost or duplicated.
- Full throughput: in_valid=out_ready=1 for 16 cycles gives 16 outputs on consecutive cycles, with latency 1.
- Reset mid-stall: with skid full, drive rst=0 for one cycle -> out_valid=0 and in_ready=1 next cycle. With MIXKEY_STATS_EN, both counters read 0.
